// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types, channel codes and helpers for the I2S transmitter
package i2s_pkg;

  localparam int DW = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    RUN        = 2'd2
  } tx_state_t;

  localparam logic [1:0] CH_MUTE   = 2'b00;
  localparam logic [1:0] CH_RIGHT  = 2'b01;
  localparam logic [1:0] CH_LEFT   = 2'b10;
  localparam logic [1:0] CH_STEREO = 2'b11;

  // Bits per sample; a programmed 0 selects a full 32-bit sample.
  function automatic logic [5:0] sample_bits(input logic [4:0] sample_size);
    return (sample_size == 5'd0) ? 6'd32 : {1'b0, sample_size};
  endfunction

endpackage

// File: rtl/i2s_tx_prefetch.sv
// rtl/i2s_tx_prefetch.sv - one-word staging buffer between the FWFT TX FIFO and the slot shifter
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   active         prefetch allowed (enabled, not idle, not muted)
//   clear          discard any staged word (transmitter being disabled)
//   take           a slot edge needs a word this clk
//   fifo_rdata     FWFT head word
//   fifo_empty     FIFO empty flag
//   fifo_rd        pop strobe, one clk per word
//   staged         staged word
//   staged_valid   staged word present
//   underrun       take with nothing staged
module i2s_tx_prefetch #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          active,
  input  logic          clear,
  input  logic          take,
  input  logic [DW-1:0] fifo_rdata,
  input  logic          fifo_empty,
  output logic          fifo_rd,
  output logic [DW-1:0] staged,
  output logic          staged_valid,
  output logic          underrun
);

  assign fifo_rd  = active & ~staged_valid & ~fifo_empty;
  assign underrun = take & ~staged_valid;

  // A pop always lands in an empty stage. A take of a valid word clears the
  // stage and blocks the pop this clk, so refill happens one clk later. A take
  // on an empty stage underruns while a simultaneous pop keeps its word for
  // the next slot that needs data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staged       <= '0;
      staged_valid <= 1'b0;
    end else if (clear) begin
      staged_valid <= 1'b0;
    end else if (fifo_rd) begin
      staged       <= fifo_rdata;
      staged_valid <= 1'b1;
    end else if (take) begin
      staged_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S / left-justified serial transmitter fed from an FWFT TX FIFO
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   en               transmit enable
//   sck, ws          master bit clock and word select (clk-synchronous, ws 0 = left)
//   sdo              serial data, updated after each sck falling edge
//   fifo_rdata       FWFT head word
//   fifo_empty       FIFO empty flag
//   fifo_rd          pop strobe
//   left_justified   1 = MSB in first slot bit, 0 = I2S one-bit delay
//   sample_size      bits per sample, 0 = 32
//   channels         10 left, 01 right, 11 stereo, 00 mute
//   underrun         one-clk pulse when a slot needed data and none was staged
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DW = i2s_pkg::DW,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          sck,
  input  logic          ws,
  output logic          sdo,
  input  logic [DW-1:0] fifo_rdata,
  input  logic          fifo_empty,
  output logic          fifo_rd,
  input  logic          left_justified,
  input  logic [SW-1:0] sample_size,
  input  logic [1:0]    channels,
  output logic          underrun
);

  tx_state_t     state, state_nx;
  logic          last_sck, last_ws;
  logic [DW-1:0] sr;
  logic          skip_r;

  logic          sck_fall, ws_edge, slot_edge, run_edge, left_edge;
  logic          need, take, active;
  logic [DW-1:0] staged, word;
  logic          staged_valid;
  logic [5:0]    n_bits, pad;

  assign sck_fall  = ~sck & last_sck;
  assign ws_edge   = ws ^ last_ws;
  assign slot_edge = sck_fall & ws_edge;
  assign left_edge = ~ws;

  // The ws fall that releases WAIT_FRAME is handled exactly like a RUN
  // left-slot edge, so the first frame is not lost.
  assign run_edge = en & slot_edge &
                    ((state == RUN) | ((state == WAIT_FRAME) & left_edge));

  // A stereo left underrun mutes the paired right slot so L/R stay aligned.
  assign need   = left_edge ? channels[1] : (channels[0] & ~skip_r);
  assign take   = run_edge & need;
  assign active = en & (state != IDLE) & (channels != CH_MUTE);

  assign n_bits = sample_bits(sample_size);
  assign pad    = 6'(DW) - n_bits;
  // Left shift drops bits above N-1 and zero-fills the slot tail.
  assign word   = (take & staged_valid) ? (staged << pad) : '0;

  i2s_tx_prefetch #(.DW(DW)) u_prefetch (
    .clk          (clk),
    .rst_n        (rst_n),
    .active       (active),
    .clear        (~en),
    .take         (take),
    .fifo_rdata   (fifo_rdata),
    .fifo_empty   (fifo_empty),
    .fifo_rd      (fifo_rd),
    .staged       (staged),
    .staged_valid (staged_valid),
    .underrun     (underrun)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:       state_nx = WAIT_FRAME;
        WAIT_FRAME: if (run_edge) state_nx = RUN;
        RUN:        state_nx = RUN;
        default:    state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_sck <= 1'b0;
      last_ws  <= 1'b1;
    end else begin
      last_sck <= sck;
      last_ws  <= ws;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdo    <= 1'b0;
      sr     <= '0;
      skip_r <= 1'b0;
    end else if (!en) begin
      sdo    <= 1'b0;
      sr     <= '0;
      skip_r <= 1'b0;
    end else if (run_edge) begin
      if (left_edge) begin
        skip_r <= (channels == CH_STEREO) & underrun;
      end
      if (left_justified) begin
        sdo <= word[DW-1];
        sr  <= word << 1;
      end else begin
        // I2S: the previous slot's last bit goes out on the ws edge.
        sdo <= sr[DW-1];
        sr  <= word;
      end
    end else if ((state == RUN) && sck_fall) begin
      sdo <= sr[DW-1];
      sr  <= sr << 1;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - directed self-checking bench for i2s_tx
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        sck = 1'b0;
  logic        ws = 1'b1;
  logic        sdo;
  logic [31:0] fifo_rdata;
  logic        fifo_empty;
  logic        fifo_rd;
  logic        left_justified = 1'b0;
  logic [4:0]  sample_size = 5'd0;
  logic [1:0]  channels = 2'b00;
  logic        underrun;

  logic [31:0] mem [256];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pops = 0;
  int          urun = 0;
  int          p0 = 0;
  int          u0 = 0;
  int          total = 0;
  int          bad = 0;
  int          g = 0;
  logic        cap [256];

  always #5 clk = ~clk;

  i2s_tx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .sck            (sck),
    .ws             (ws),
    .sdo            (sdo),
    .fifo_rdata     (fifo_rdata),
    .fifo_empty     (fifo_empty),
    .fifo_rd        (fifo_rd),
    .left_justified (left_justified),
    .sample_size    (sample_size),
    .channels       (channels),
    .underrun       (underrun)
  );

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_rdata = mem[rd_ptr[7:0]];

  always @(posedge clk) begin
    if (!rst_n) rd_ptr <= wr_ptr;
    else if (fifo_rd) rd_ptr <= rd_ptr + 1;
  end

  always @(negedge clk) begin
    if (fifo_rd) pops = pops + 1;
    if (underrun) urun = urun + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // One sck period (3 clk high, 3 clk low); ws changes with the fall and
  // sdo for that fall is captured mid-low.
  task automatic do_bits(input int n);
    for (int i = 0; i < n; i++) begin
      sck = 1'b1;
      repeat (3) tick();
      sck = 1'b0;
      ws  = g[5];
      repeat (2) tick();
      cap[g] = sdo;
      tick();
      g++;
    end
  endtask

  function automatic logic [31:0] slot(input int s);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = cap[32*s+i];
    return r;
  endfunction

  task automatic start(input logic lj, input logic [4:0] ss, input logic [1:0] ch);
    en = 1'b0;
    sck = 1'b0;
    ws = 1'b1;
    rst_n = 1'b0;
    left_justified = lj;
    sample_size = ss;
    channels = ch;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    g = 0;
    p0 = pops;
    u0 = urun;
  endtask

  task automatic go();
    en = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      cap[i] = 1'b0;
    end

    repeat (2) tick();
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);

    // Stereo I2S, 16-bit samples
    start(1'b0, 5'd16, 2'b11);
    push(32'h0000A5C3);
    push(32'h00001234);
    go();
    do_bits(64);
    check("t1_left", slot(0), 32'h52E18000);
    check("t1_right", slot(1), 32'h091A0000);
    check("t1_pops", 32'(pops - p0), 32'd2);
    check("t1_urun", 32'(urun - u0), 32'd0);

    // Left-justified, 32-bit, left only
    start(1'b1, 5'd0, 2'b10);
    push(32'h80000001);
    go();
    do_bits(64);
    check("t2_left", slot(0), 32'h80000001);
    check("t2_right", slot(1), 32'h00000000);
    check("t2_pops", 32'(pops - p0), 32'd1);
    check("t2_urun", 32'(urun - u0), 32'd0);

    // I2S, 32-bit, LSB of one word abuts MSB of the next
    start(1'b0, 5'd0, 2'b11);
    push(32'h00000001);
    push(32'h80000000);
    go();
    do_bits(64);
    check("t3_left", slot(0), 32'h00000000);
    check("t3_right", slot(1), 32'hC0000000);
    check("t3_pops", 32'(pops - p0), 32'd2);

    // Stereo underrun at the first left edge, words arrive mid-slot
    start(1'b0, 5'd16, 2'b11);
    go();
    do_bits(8);
    push(32'h0000ABCD);
    push(32'h00001357);
    do_bits(56);
    check("t4_pops_f1", 32'(pops - p0), 32'd1);
    check("t4_urun_f1", 32'(urun - u0), 32'd1);
    do_bits(64);
    check("t4_l0", slot(0), 32'h00000000);
    check("t4_r0", slot(1), 32'h00000000);
    check("t4_l1", slot(2), 32'h55E68000);
    check("t4_r1", slot(3), 32'h09AB8000);
    check("t4_pops", 32'(pops - p0), 32'd2);
    check("t4_urun", 32'(urun - u0), 32'd1);

    // Left only, 8-bit samples
    start(1'b0, 5'd8, 2'b10);
    push(32'h000000FF);
    push(32'h0000000F);
    go();
    do_bits(128);
    check("t5_l0", slot(0), 32'h7F800000);
    check("t5_r0", slot(1), 32'h00000000);
    check("t5_l1", slot(2), 32'h07800000);
    check("t5_r1", slot(3), 32'h00000000);
    check("t5_pops", 32'(pops - p0), 32'd2);
    check("t5_urun", 32'(urun - u0), 32'd0);

    // Disable mid-slot with a word staged, re-enable mid right slot
    start(1'b1, 5'd0, 2'b11);
    push(32'hFFFFFFFF);
    push(32'hAAAAAAAA);
    push(32'h55555555);
    go();
    do_bits(10);
    check("t6_sdo_on", 32'(sdo), 32'd1);
    check("t6_pops_on", 32'(pops - p0), 32'd2);
    en = 1'b0;
    tick();
    check("t6_sdo_off", 32'(sdo), 32'd0);
    do_bits(38);
    check("t6_pops_off", 32'(pops - p0), 32'd2);
    en = 1'b1;
    do_bits(80);
    check("t6_l0", slot(0), 32'hFFC00000);
    check("t6_r0", slot(1), 32'h00000000);
    check("t6_l1", slot(2), 32'h55555555);
    check("t6_r1", slot(3), 32'h00000000);
    check("t6_pops", 32'(pops - p0), 32'd3);
    check("t6_urun", 32'(urun - u0), 32'd1);

    // Asynchronous reset mid-slot
    start(1'b1, 5'd0, 2'b10);
    push(32'hFFFFFFFF);
    go();
    do_bits(5);
    push(32'h12345678);
    #1;
    check("t7_sdo_pre", 32'(sdo), 32'd1);
    check("t7_rd_pre", 32'(fifo_rd), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t7_sdo_rst", 32'(sdo), 32'd0);
    check("t7_rd_rst", 32'(fifo_rd), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
